lw_to_hw_bridge: RTL and testbench
==================================

// Module: lw_to_hw_bridge
// PURPOSE
//  Lightweight-to-heavyweight TileLink bridge: LW master side (single-beat, no source, in-order D) in, HW slave side
//  (source-tagged, out-of-order D) out. Each LW request gets a HW source ID from a rotating pool, so up to
//  OUTSTANDING requests are in flight. A reorder buffer returns HW responses to the LW side in request order.
//  Lets LW-only masters (simple cores, DMA shims) reach HW fabric targets with pipelined throughput.
// PARAMETERS
//  TL_RS        4   HW source width
//  TL_AW        28  address width
//  OUTSTANDING  4   in-flight slots; power of 2, 2..2^TL_RS
//  SOURCE_BASE  0   first HW source ID; IDs SOURCE_BASE..SOURCE_BASE+OUTSTANDING-1 are owned by this bridge
// PORTS
//  tilelink_clock_i in 1 clock; tilelink_reset_i in 1 sync reset, ACTIVE LOW (0 = reset)
//  lw_a_opcode/param in 3/3; lw_a_size in 4; lw_a_address in TL_AW; lw_a_mask in 4; lw_a_data in 32; lw_a_corrupt in 1
//  lw_a_valid in 1; lw_a_ready out 1
//  lw_d_opcode out 3; lw_d_param out 2; lw_d_size out 4; lw_d_denied out 1; lw_d_data out 32; lw_d_corrupt out 1
//  lw_d_valid out 1; lw_d_ready in 1
//  hw_a_opcode/param out 3/3; hw_a_size out 4; hw_a_source out TL_RS; hw_a_address out TL_AW; hw_a_mask out 4
//  hw_a_data out 32; hw_a_corrupt out 1; hw_a_valid out 1; hw_a_ready in 1
//  hw_d_opcode in 3; hw_d_param in 2; hw_d_size in 4; hw_d_source in TL_RS; hw_d_denied in 1; hw_d_data in 32
//  hw_d_corrupt in 1; hw_d_valid in 1; hw_d_ready out 1
// BEHAVIOUR
//  Reset (tilelink_reset_i==0 at edge): lw_d_valid=0, hw_a_valid=0, all other outputs 0; slots invalid; alloc_ptr=
//   retire_ptr=0; count=0. Mid-operation reset drops in-flight state; later hw_d beats hit invalid slots, are ignored.
//  Handshakes: transfer on valid&ready at edge; outputs hold stable while valid&~ready.
//  Accept: lw_a_ready = (count<OUTSTANDING) & (~hw_a_valid | hw_a_ready). On accept, slot[alloc_ptr] set valid, done=0,
//   stores size and opcode class; alloc_ptr++ (wraps mod OUTSTANDING); count++.
//  Legal request: opcode in {PutFull 0, PutPartial 1, Get 4} and size<=2. Next edge: hw_a_* <= lw_a_* fields,
//   hw_a_source <= SOURCE_BASE+slot index, hw_a_valid=1 (1-cycle latency). hw_a_valid drops when handshake with no new accept.
//  Illegal request: not forwarded; slot marked done at once, denied=1, corrupt=(opcode==Get), data=0,
//   response opcode AccessAckData(1) for Get else AccessAck(0). Order still preserved.
//  hw_d_ready tied 1 (slot storage pre-allocated). On hw_d_valid: idx = hw_d_source-SOURCE_BASE (low log2(OUTSTANDING)
//   bits). If source in range and slot valid&~done: store opcode/param/size/denied/data/corrupt, done=1. Else ignore.
//  Retire: LW D is a registered stage. When slot[retire_ptr] valid&done and (~lw_d_valid | lw_d_ready): load lw_d_*
//   from slot, lw_d_valid=1, clear slot valid, retire_ptr++, count--. Otherwise on lw_d_ready handshake lw_d_valid=0.
//  Latency hw_d beat -> lw_d_valid: 2 edges (slot write, then output load). One retire per cycle max.
//  Simultaneous accept+retire: count unchanged; same-slot alloc impossible (full blocks). hw_d for slot being
//   retired same cycle cannot occur (retire requires done).
//  Full (count==OUTSTANDING): lw_a_ready=0 until a retire. Empty: lw_d_valid falls after last handshake.
//  Widths: count is $clog2(OUTSTANDING)+1 bits; pointers $clog2(OUTSTANDING) bits, natural wrap.
// STRUCTURE
//  tl_pkg: opcode constants TL_PUT_FULL=0, TL_PUT_PARTIAL=1, TL_GET=4, TL_ACCESS_ACK=0, TL_ACCESS_ACK_DATA=1;
//   typedef tl_d_beat_t {opcode,param,size,denied,data,corrupt}.
//  Sub-module lw_to_hw_rob: slot array of tl_d_beat_t + valid/done bits, alloc/retire pointers, count, full/head_done.
//  Top: A-channel output register, legality check, D-channel output register.
// TESTING
//  Single Get addr 0x100, hw_d AccessAckData data 0xDEADBEEF -> hw_a_source=0 next cycle; lw_d data 0xDEADBEEF 2 edges later.
//  4 Gets back-to-back, hw_d order sources 3,1,0,2 -> lw_d returns data in issue order 0,1,2,3; 5th Get stalls until first retire.
//  Put size 3 (illegal) between two Gets -> not on hw_a; lw_d order Get,AccessAck denied=1,Get.
//  hw_a_ready=0 for 5 cycles with 2 queued -> hw_a fields stable; lw_a_ready=0 while hw_a blocked.
//  lw_d_ready=0 with 4 done slots, then 1 -> one retire per cycle, count 4->0, no loss; stray hw_d source 9 ignored.
//  Reset asserted with 3 in flight -> all valids 0 next edge; late hw_d beats produce no lw_d_valid.

Source files
------------

// File: rtl/tl_pkg.sv
// TileLink opcode constants, the D-channel beat record shared by the bridge
// and its reorder buffer, and the request legality rule.
package tl_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [3:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } tl_d_beat_t;

    // Only single-beat Put/Get of at most one 32-bit word can cross the bridge.
    function automatic logic tl_lw_legal(input logic [2:0] opcode, input logic [3:0] size);
        return ((opcode == TL_PUT_FULL) || (opcode == TL_PUT_PARTIAL) || (opcode == TL_GET))
               && (size <= 4'd2);
    endfunction

endpackage

// File: rtl/lw_to_hw_rob.sv
// Reorder buffer: one slot per in-flight request, allocated in issue order,
// filled out of order by source-tagged responses, retired in issue order.
module lw_to_hw_rob
    import tl_pkg::*;
#(
    parameter int TL_RS       = 4,
    parameter int OUTSTANDING = 4,
    parameter int SOURCE_BASE = 0,
    localparam int PTR_W      = $clog2(OUTSTANDING),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             tilelink_clock_i,
    input  logic             tilelink_reset_i,
    input  logic             alloc_en,
    input  logic             alloc_done,
    input  tl_d_beat_t       alloc_beat,
    output logic [PTR_W-1:0] alloc_idx,
    output logic             full,
    input  logic             wr_en,
    input  logic [TL_RS-1:0] wr_source,
    input  tl_d_beat_t       wr_beat,
    input  logic             retire_en,
    output logic             head_done,
    output tl_d_beat_t       head_beat
);

    tl_d_beat_t             slot_beat [OUTSTANDING];
    logic [OUTSTANDING-1:0] slot_valid;
    logic [OUTSTANDING-1:0] slot_done;
    logic [PTR_W-1:0]       alloc_ptr;
    logic [PTR_W-1:0]       retire_ptr;
    logic [CNT_W-1:0]       count;

    logic [TL_RS-1:0] src_off;
    logic             src_in_range;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_hit;

    // A response lands only on a slot we own that is still waiting for it;
    // stray sources and beats for slots dropped by reset fall through here.
    assign src_off      = wr_source - TL_RS'(SOURCE_BASE);
    assign src_in_range = ({1'b0, src_off} < (TL_RS+1)'(OUTSTANDING));
    assign wr_idx       = src_off[PTR_W-1:0];
    assign wr_hit       = wr_en & src_in_range & slot_valid[wr_idx] & ~slot_done[wr_idx];

    assign full      = (count == CNT_W'(OUTSTANDING));
    assign alloc_idx = alloc_ptr;
    assign head_done = slot_valid[retire_ptr] & slot_done[retire_ptr];
    assign head_beat = slot_beat[retire_ptr];

    // Slot bookkeeping: valid/done flags, pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge tilelink_clock_i) begin
        if (!tilelink_reset_i) begin
            slot_valid <= '0;
            slot_done  <= '0;
            alloc_ptr  <= '0;
            retire_ptr <= '0;
            count      <= '0;
        end else begin
            if (wr_hit) begin
                slot_done[wr_idx] <= 1'b1;
            end
            if (alloc_en) begin
                slot_valid[alloc_ptr] <= 1'b1;
                slot_done[alloc_ptr]  <= alloc_done;
                alloc_ptr             <= alloc_ptr + PTR_W'(1);
            end
            if (retire_en) begin
                slot_valid[retire_ptr] <= 1'b0;
                retire_ptr             <= retire_ptr + PTR_W'(1);
            end
            case ({alloc_en, retire_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot payload storage.
    // NOTE: payload is left unreset on purpose; slot_valid/slot_done gate every read of it.
    always_ff @(posedge tilelink_clock_i) begin
        if (wr_hit) begin
            slot_beat[wr_idx] <= wr_beat;
        end
        if (alloc_en) begin
            slot_beat[alloc_ptr] <= alloc_beat;
        end
    end

endmodule

// File: rtl/lw_to_hw_bridge.sv
// Lightweight-to-heavyweight TileLink bridge: tags LW requests with pool
// source IDs, forwards legal ones through a registered A stage, and returns
// responses in request order through a registered D stage.
module lw_to_hw_bridge
    import tl_pkg::*;
#(
    parameter int TL_RS       = 4,
    parameter int TL_AW       = 28,
    parameter int OUTSTANDING = 4,
    parameter int SOURCE_BASE = 0
) (
    input  logic             tilelink_clock_i,
    input  logic             tilelink_reset_i,
    input  logic [2:0]       lw_a_opcode,
    input  logic [2:0]       lw_a_param,
    input  logic [3:0]       lw_a_size,
    input  logic [TL_AW-1:0] lw_a_address,
    input  logic [3:0]       lw_a_mask,
    input  logic [31:0]      lw_a_data,
    input  logic             lw_a_corrupt,
    input  logic             lw_a_valid,
    output logic             lw_a_ready,
    output logic [2:0]       lw_d_opcode,
    output logic [1:0]       lw_d_param,
    output logic [3:0]       lw_d_size,
    output logic             lw_d_denied,
    output logic [31:0]      lw_d_data,
    output logic             lw_d_corrupt,
    output logic             lw_d_valid,
    input  logic             lw_d_ready,
    output logic [2:0]       hw_a_opcode,
    output logic [2:0]       hw_a_param,
    output logic [3:0]       hw_a_size,
    output logic [TL_RS-1:0] hw_a_source,
    output logic [TL_AW-1:0] hw_a_address,
    output logic [3:0]       hw_a_mask,
    output logic [31:0]      hw_a_data,
    output logic             hw_a_corrupt,
    output logic             hw_a_valid,
    input  logic             hw_a_ready,
    input  logic [2:0]       hw_d_opcode,
    input  logic [1:0]       hw_d_param,
    input  logic [3:0]       hw_d_size,
    input  logic [TL_RS-1:0] hw_d_source,
    input  logic             hw_d_denied,
    input  logic [31:0]      hw_d_data,
    input  logic             hw_d_corrupt,
    input  logic             hw_d_valid,
    output logic             hw_d_ready
);

    localparam int PTR_W = $clog2(OUTSTANDING);

    logic             rob_full;
    logic [PTR_W-1:0] alloc_idx;
    logic             head_done;
    tl_d_beat_t       head_beat;
    logic             accept;
    logic             req_legal;
    logic             retire;
    tl_d_beat_t       illegal_beat;
    tl_d_beat_t       hw_d_beat;

    // Every owned source has a pre-allocated slot, so responses never stall.
    assign hw_d_ready = 1'b1;

    assign lw_a_ready = ~rob_full & (~hw_a_valid | hw_a_ready);
    assign accept     = lw_a_valid & lw_a_ready;
    assign req_legal  = tl_lw_legal(lw_a_opcode, lw_a_size);
    assign retire     = head_done & (~lw_d_valid | lw_d_ready);

    // Locally generated denial for requests the fabric must never see.
    // NOTE: every field gets a value on every pass, so no latch can be inferred.
    always_comb begin
        illegal_beat         = '0;
        illegal_beat.opcode  = (lw_a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
        illegal_beat.size    = lw_a_size;
        illegal_beat.denied  = 1'b1;
        illegal_beat.corrupt = (lw_a_opcode == TL_GET);
    end

    // Pack the incoming HW response into a slot record.
    always_comb begin
        hw_d_beat         = '0;
        hw_d_beat.opcode  = hw_d_opcode;
        hw_d_beat.param   = hw_d_param;
        hw_d_beat.size    = hw_d_size;
        hw_d_beat.denied  = hw_d_denied;
        hw_d_beat.data    = hw_d_data;
        hw_d_beat.corrupt = hw_d_corrupt;
    end

    lw_to_hw_rob #(
        .TL_RS       (TL_RS),
        .OUTSTANDING (OUTSTANDING),
        .SOURCE_BASE (SOURCE_BASE)
    ) u_rob (
        .tilelink_clock_i (tilelink_clock_i),
        .tilelink_reset_i (tilelink_reset_i),
        .alloc_en         (accept),
        .alloc_done       (~req_legal),
        .alloc_beat       (illegal_beat),
        .alloc_idx        (alloc_idx),
        .full             (rob_full),
        .wr_en            (hw_d_valid),
        .wr_source        (hw_d_source),
        .wr_beat          (hw_d_beat),
        .retire_en        (retire),
        .head_done        (head_done),
        .head_beat        (head_beat)
    );

    // HW A output stage: load a legal accepted request, drop valid once taken.
    always_ff @(posedge tilelink_clock_i) begin
        if (!tilelink_reset_i) begin
            hw_a_opcode  <= '0;
            hw_a_param   <= '0;
            hw_a_size    <= '0;
            hw_a_source  <= '0;
            hw_a_address <= '0;
            hw_a_mask    <= '0;
            hw_a_data    <= '0;
            hw_a_corrupt <= 1'b0;
            hw_a_valid   <= 1'b0;
        end else if (accept && req_legal) begin
            hw_a_opcode  <= lw_a_opcode;
            hw_a_param   <= lw_a_param;
            hw_a_size    <= lw_a_size;
            hw_a_source  <= TL_RS'(SOURCE_BASE) + TL_RS'(alloc_idx);
            hw_a_address <= lw_a_address;
            hw_a_mask    <= lw_a_mask;
            hw_a_data    <= lw_a_data;
            hw_a_corrupt <= lw_a_corrupt;
            hw_a_valid   <= 1'b1;
        end else if (hw_a_ready) begin
            hw_a_valid <= 1'b0;
        end
    end

    // LW D output stage: load the head slot when it is done and the stage is free.
    always_ff @(posedge tilelink_clock_i) begin
        if (!tilelink_reset_i) begin
            lw_d_opcode  <= '0;
            lw_d_param   <= '0;
            lw_d_size    <= '0;
            lw_d_denied  <= 1'b0;
            lw_d_data    <= '0;
            lw_d_corrupt <= 1'b0;
            lw_d_valid   <= 1'b0;
        end else if (retire) begin
            lw_d_opcode  <= head_beat.opcode;
            lw_d_param   <= head_beat.param;
            lw_d_size    <= head_beat.size;
            lw_d_denied  <= head_beat.denied;
            lw_d_data    <= head_beat.data;
            lw_d_corrupt <= head_beat.corrupt;
            lw_d_valid   <= 1'b1;
        end else if (lw_d_ready) begin
            lw_d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lw_to_hw_bridge.sv
// Directed bench for lw_to_hw_bridge: a legality/response vector table plus
// hand-written multi-cycle sequences for ordering, back-pressure and reset.
module tb_lw_to_hw_bridge;
    import tl_pkg::*;

    localparam int TL_RS = 4;
    localparam int TL_AW = 28;

    logic             tilelink_clock_i;
    logic             tilelink_reset_i;
    logic [2:0]       lw_a_opcode;
    logic [2:0]       lw_a_param;
    logic [3:0]       lw_a_size;
    logic [TL_AW-1:0] lw_a_address;
    logic [3:0]       lw_a_mask;
    logic [31:0]      lw_a_data;
    logic             lw_a_corrupt;
    logic             lw_a_valid;
    logic             lw_a_ready;
    logic [2:0]       lw_d_opcode;
    logic [1:0]       lw_d_param;
    logic [3:0]       lw_d_size;
    logic             lw_d_denied;
    logic [31:0]      lw_d_data;
    logic             lw_d_corrupt;
    logic             lw_d_valid;
    logic             lw_d_ready;
    logic [2:0]       hw_a_opcode;
    logic [2:0]       hw_a_param;
    logic [3:0]       hw_a_size;
    logic [TL_RS-1:0] hw_a_source;
    logic [TL_AW-1:0] hw_a_address;
    logic [3:0]       hw_a_mask;
    logic [31:0]      hw_a_data;
    logic             hw_a_corrupt;
    logic             hw_a_valid;
    logic             hw_a_ready;
    logic [2:0]       hw_d_opcode;
    logic [1:0]       hw_d_param;
    logic [3:0]       hw_d_size;
    logic [TL_RS-1:0] hw_d_source;
    logic             hw_d_denied;
    logic [31:0]      hw_d_data;
    logic             hw_d_corrupt;
    logic             hw_d_valid;
    logic             hw_d_ready;

    int errors = 0;
    int checks = 0;

    lw_to_hw_bridge #(
        .TL_RS       (TL_RS),
        .TL_AW       (TL_AW),
        .OUTSTANDING (4),
        .SOURCE_BASE (0)
    ) dut (
        .tilelink_clock_i (tilelink_clock_i),
        .tilelink_reset_i (tilelink_reset_i),
        .lw_a_opcode      (lw_a_opcode),
        .lw_a_param       (lw_a_param),
        .lw_a_size        (lw_a_size),
        .lw_a_address     (lw_a_address),
        .lw_a_mask        (lw_a_mask),
        .lw_a_data        (lw_a_data),
        .lw_a_corrupt     (lw_a_corrupt),
        .lw_a_valid       (lw_a_valid),
        .lw_a_ready       (lw_a_ready),
        .lw_d_opcode      (lw_d_opcode),
        .lw_d_param       (lw_d_param),
        .lw_d_size        (lw_d_size),
        .lw_d_denied      (lw_d_denied),
        .lw_d_data        (lw_d_data),
        .lw_d_corrupt     (lw_d_corrupt),
        .lw_d_valid       (lw_d_valid),
        .lw_d_ready       (lw_d_ready),
        .hw_a_opcode      (hw_a_opcode),
        .hw_a_param       (hw_a_param),
        .hw_a_size        (hw_a_size),
        .hw_a_source      (hw_a_source),
        .hw_a_address     (hw_a_address),
        .hw_a_mask        (hw_a_mask),
        .hw_a_data        (hw_a_data),
        .hw_a_corrupt     (hw_a_corrupt),
        .hw_a_valid       (hw_a_valid),
        .hw_a_ready       (hw_a_ready),
        .hw_d_opcode      (hw_d_opcode),
        .hw_d_param       (hw_d_param),
        .hw_d_size        (hw_d_size),
        .hw_d_source      (hw_d_source),
        .hw_d_denied      (hw_d_denied),
        .hw_d_data        (hw_d_data),
        .hw_d_corrupt     (hw_d_corrupt),
        .hw_d_valid       (hw_d_valid),
        .hw_d_ready       (hw_d_ready)
    );

    initial begin
        tilelink_clock_i = 1'b0;
        forever #5 tilelink_clock_i = ~tilelink_clock_i;
    end

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic        legal;
        logic [2:0]  d_op;
        logic        denied;
        logic        corrupt;
        logic [31:0] d_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge tilelink_clock_i);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [3:0] size,
                           input logic [TL_AW-1:0] addr, input logic [31:0] data);
        lw_a_opcode  = op;
        lw_a_size    = size;
        lw_a_address = addr;
        lw_a_data    = data;
        lw_a_param   = 3'd0;
        lw_a_mask    = 4'hF;
        lw_a_corrupt = 1'b0;
        lw_a_valid   = 1'b1;
    endtask

    task automatic drive_d(input logic [TL_RS-1:0] src, input logic [2:0] op,
                           input logic [31:0] data, input logic denied, input logic corrupt);
        hw_d_source  = src;
        hw_d_opcode  = op;
        hw_d_data    = data;
        hw_d_denied  = denied;
        hw_d_corrupt = corrupt;
        hw_d_param   = 2'd0;
        hw_d_size    = 4'd2;
        hw_d_valid   = 1'b1;
    endtask

    task automatic do_reset();
        lw_a_valid       = 1'b0;
        hw_d_valid       = 1'b0;
        tilelink_reset_i = 1'b0;
        step();
        step();
        tilelink_reset_i = 1'b1;
    endtask

    initial begin
        tilelink_reset_i = 1'b0;
        lw_a_opcode = '0; lw_a_param = '0; lw_a_size = '0; lw_a_address = '0;
        lw_a_mask = '0; lw_a_data = '0; lw_a_corrupt = 1'b0; lw_a_valid = 1'b0;
        lw_d_ready = 1'b1;
        hw_a_ready = 1'b1;
        hw_d_opcode = '0; hw_d_param = '0; hw_d_size = '0; hw_d_source = '0;
        hw_d_denied = 1'b0; hw_d_data = '0; hw_d_corrupt = 1'b0; hw_d_valid = 1'b0;

        vecs[0] = '{op: TL_GET,         size: 4'd2, legal: 1'b1, d_op: 3'd1, denied: 1'b0, corrupt: 1'b0, d_data: 32'h1234_5678};
        vecs[1] = '{op: TL_PUT_FULL,    size: 4'd2, legal: 1'b1, d_op: 3'd0, denied: 1'b0, corrupt: 1'b0, d_data: 32'h0};
        vecs[2] = '{op: TL_PUT_PARTIAL, size: 4'd0, legal: 1'b1, d_op: 3'd0, denied: 1'b0, corrupt: 1'b0, d_data: 32'h0};
        vecs[3] = '{op: TL_PUT_FULL,    size: 4'd3, legal: 1'b0, d_op: 3'd0, denied: 1'b1, corrupt: 1'b0, d_data: 32'h0};
        vecs[4] = '{op: TL_GET,         size: 4'd3, legal: 1'b0, d_op: 3'd1, denied: 1'b1, corrupt: 1'b1, d_data: 32'h0};
        vecs[5] = '{op: 3'd2,           size: 4'd2, legal: 1'b0, d_op: 3'd0, denied: 1'b1, corrupt: 1'b0, d_data: 32'h0};
        vecs[6] = '{op: TL_GET,         size: 4'd1, legal: 1'b1, d_op: 3'd1, denied: 1'b1, corrupt: 1'b1, d_data: 32'hCAFE_0001};

        // Reset state.
        do_reset();
        check("rst hw_a_valid", hw_a_valid, 0);
        check("rst lw_d_valid", lw_d_valid, 0);
        check("rst hw_a_source", hw_a_source, 0);
        check("rst lw_d_data", lw_d_data, 0);
        check("rst lw_a_ready", lw_a_ready, 1);
        check("rst hw_d_ready", hw_d_ready, 1);

        // Single Get with fixed latencies.
        drive_a(TL_GET, 4'd2, 28'h100, 32'h0);
        step();
        lw_a_valid = 1'b0;
        check("get hw_a_valid", hw_a_valid, 1);
        check("get hw_a_source", hw_a_source, 0);
        check("get hw_a_address", hw_a_address, 28'h100);
        check("get hw_a_opcode", hw_a_opcode, TL_GET);
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        check("get hw_a drop", hw_a_valid, 0);
        check("get lw_d not yet", lw_d_valid, 0);
        step();
        check("get lw_d_valid", lw_d_valid, 1);
        check("get lw_d_data", lw_d_data, 32'hDEAD_BEEF);
        check("get lw_d_opcode", lw_d_opcode, TL_ACCESS_ACK_DATA);
        step();
        check("get lw_d empty", lw_d_valid, 0);

        // Legality / response-passthrough table.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_a(vecs[i].op, vecs[i].size, 28'h1000 + 28'(i * 4), 32'(i));
            step();
            lw_a_valid = 1'b0;
            check($sformatf("vec%0d forwarded", i), hw_a_valid, vecs[i].legal);
            if (vecs[i].legal) begin
                check($sformatf("vec%0d source", i), hw_a_source, i % 4);
                check($sformatf("vec%0d a_size", i), hw_a_size, vecs[i].size);
                drive_d(4'(i % 4), vecs[i].d_op, vecs[i].d_data, vecs[i].denied, vecs[i].corrupt);
                step();
                hw_d_valid = 1'b0;
            end
            step();
            check($sformatf("vec%0d d_valid", i), lw_d_valid, 1);
            check($sformatf("vec%0d d_opcode", i), lw_d_opcode, vecs[i].d_op);
            check($sformatf("vec%0d d_denied", i), lw_d_denied, vecs[i].denied);
            check($sformatf("vec%0d d_corrupt", i), lw_d_corrupt, vecs[i].corrupt);
            check($sformatf("vec%0d d_data", i), lw_d_data, vecs[i].d_data);
            step();
            check($sformatf("vec%0d d_drain", i), lw_d_valid, 0);
        end

        // Four Gets, responses out of order 3,1,0,2; fifth Get stalls while full.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_a(TL_GET, 4'd2, 28'h400 + 28'(i * 4), 32'h0);
            check($sformatf("ooo accept%0d ready", i), lw_a_ready, 1);
            step();
            check($sformatf("ooo src%0d", i), hw_a_source, i);
        end
        drive_a(TL_GET, 4'd2, 28'h500, 32'h0);
        check("ooo full ready", lw_a_ready, 0);
        drive_d(4'd3, TL_ACCESS_ACK_DATA, 32'hA3, 1'b0, 1'b0);
        step();
        check("ooo stall1", lw_a_ready, 0);
        drive_d(4'd1, TL_ACCESS_ACK_DATA, 32'hA1, 1'b0, 1'b0);
        step();
        check("ooo stall2", lw_a_ready, 0);
        check("ooo no d yet", lw_d_valid, 0);
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'hA0, 1'b0, 1'b0);
        step();
        check("ooo head latency", lw_d_valid, 0);
        drive_d(4'd2, TL_ACCESS_ACK_DATA, 32'hA2, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        check("ooo d0", lw_d_data, 32'hA0);
        check("ooo ready after retire", lw_a_ready, 1);
        step();
        lw_a_valid = 1'b0;
        check("ooo d1", lw_d_data, 32'hA1);
        check("ooo 5th src", hw_a_source, 0);
        check("ooo 5th valid", hw_a_valid, 1);
        check("ooo 5th addr", hw_a_address, 28'h500);
        step();
        check("ooo d2", lw_d_data, 32'hA2);
        step();
        check("ooo d3", lw_d_data, 32'hA3);
        step();
        check("ooo 5th pending", lw_d_valid, 0);
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'h55, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        step();
        check("ooo d5", lw_d_data, 32'h55);
        step();

        // Illegal Put between two Gets keeps order.
        do_reset();
        drive_a(TL_GET, 4'd2, 28'h10, 32'h0);
        step();
        check("mix g0 src", hw_a_source, 0);
        drive_a(TL_PUT_FULL, 4'd3, 28'h20, 32'h0);
        step();
        check("mix put not fwd", hw_a_valid, 0);
        drive_a(TL_GET, 4'd2, 28'h30, 32'h0);
        step();
        lw_a_valid = 1'b0;
        check("mix g2 src", hw_a_source, 2);
        check("mix g2 addr", hw_a_address, 28'h30);
        drive_d(4'd2, TL_ACCESS_ACK_DATA, 32'h22, 1'b0, 1'b0);
        step();
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'h11, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        step();
        check("mix d0 data", lw_d_data, 32'h11);
        step();
        check("mix d1 opcode", lw_d_opcode, TL_ACCESS_ACK);
        check("mix d1 denied", lw_d_denied, 1);
        check("mix d1 valid", lw_d_valid, 1);
        step();
        check("mix d2 data", lw_d_data, 32'h22);
        step();
        check("mix empty", lw_d_valid, 0);

        // HW A back-pressure holds the output stage and blocks acceptance.
        do_reset();
        hw_a_ready = 1'b0;
        drive_a(TL_GET, 4'd2, 28'h200, 32'h0);
        step();
        drive_a(TL_PUT_FULL, 4'd2, 28'h300, 32'h5A5A);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d addr", i), hw_a_address, 28'h200);
            check($sformatf("bp%0d ready", i), lw_a_ready, 0);
            step();
        end
        hw_a_ready = 1'b1;
        #1;
        check("bp release ready", lw_a_ready, 1);
        step();
        lw_a_valid = 1'b0;
        check("bp 2nd addr", hw_a_address, 28'h300);
        check("bp 2nd src", hw_a_source, 1);
        check("bp 2nd data", hw_a_data, 32'h5A5A);
        step();
        check("bp drop", hw_a_valid, 0);

        // LW D back-pressure with all slots done; stray source 9 ignored.
        do_reset();
        lw_d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(TL_GET, 4'd2, 28'h600 + 28'(i * 4), 32'h0);
            step();
        end
        lw_a_valid = 1'b0;
        check("dbp full", lw_a_ready, 0);
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'hB0, 1'b0, 1'b0);
        step();
        drive_d(4'd9, TL_ACCESS_ACK_DATA, 32'h99, 1'b0, 1'b0);
        step();
        drive_d(4'd1, TL_ACCESS_ACK_DATA, 32'hB1, 1'b0, 1'b0);
        step();
        drive_d(4'd2, TL_ACCESS_ACK_DATA, 32'hB2, 1'b0, 1'b0);
        step();
        drive_d(4'd3, TL_ACCESS_ACK_DATA, 32'hB3, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        step();
        step();
        check("dbp hold valid", lw_d_valid, 1);
        check("dbp hold data", lw_d_data, 32'hB0);
        lw_d_ready = 1'b1;
        step();
        check("dbp d1", lw_d_data, 32'hB1);
        step();
        check("dbp d2", lw_d_data, 32'hB2);
        step();
        check("dbp d3", lw_d_data, 32'hB3);
        step();
        check("dbp empty", lw_d_valid, 0);
        check("dbp ready", lw_a_ready, 1);

        // Reset with three requests in flight; late responses are dropped.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_a(TL_GET, 4'd2, 28'h700 + 28'(i * 4), 32'h0);
            step();
        end
        lw_a_valid = 1'b0;
        tilelink_reset_i = 1'b0;
        step();
        tilelink_reset_i = 1'b1;
        check("mrst hw_a_valid", hw_a_valid, 0);
        check("mrst lw_d_valid", lw_d_valid, 0);
        for (int i = 0; i < 3; i++) begin
            drive_d(4'(i), TL_ACCESS_ACK_DATA, 32'hE0 + 32'(i), 1'b0, 1'b0);
            step();
            check($sformatf("mrst late%0d", i), lw_d_valid, 0);
        end
        hw_d_valid = 1'b0;
        step();
        check("mrst quiet", lw_d_valid, 0);
        drive_a(TL_GET, 4'd2, 28'h800, 32'h0);
        step();
        lw_a_valid = 1'b0;
        check("mrst new src", hw_a_source, 0);
        step();
        step();
        check("mrst slot not done", lw_d_valid, 0);
        drive_d(4'd0, TL_ACCESS_ACK_DATA, 32'h77, 1'b0, 1'b0);
        step();
        hw_d_valid = 1'b0;
        step();
        check("mrst new data", lw_d_data, 32'h77);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
